// File: rtl/lc4_retire_monitor_if.sv
// Retire-monitor bus: processor retire signals, host controls and monitor results.
// master = processor/host side, slave = lc4_retire_monitor.
interface lc4_retire_monitor_if #(
    parameter int INSN          = 19,
    parameter int IADDR         = 10,
    parameter int REG_ADDR_BITS = 5,
    parameter int CNT_W         = 32
);
    localparam int TW = INSN + IADDR + REG_ADDR_BITS + 3;

    logic                     gwe;
    logic                     clear;
    logic [1:0]               test_stall;
    logic [IADDR:0]           test_cur_pc;
    logic [INSN:0]            test_cur_insn;
    logic                     test_regfile_we;
    logic [REG_ADDR_BITS-1:0] test_regfile_wsel;
    logic                     trace_pop;

    logic [CNT_W-1:0]         cnt_cycles;
    logic [CNT_W-1:0]         cnt_exec;
    logic [CNT_W-1:0]         cnt_cache_stall;
    logic [CNT_W-1:0]         cnt_branch_stall;
    logic [CNT_W-1:0]         cnt_load_stall;
    logic                     halted;
    logic                     hung;
    logic                     trace_valid;
    logic [TW-1:0]            trace_data;
    logic                     trace_overflow;

    modport master (
        output gwe, clear, test_stall, test_cur_pc, test_cur_insn,
        output test_regfile_we, test_regfile_wsel, trace_pop,
        input  cnt_cycles, cnt_exec, cnt_cache_stall,
        input  cnt_branch_stall, cnt_load_stall,
        input  halted, hung, trace_valid, trace_data, trace_overflow
    );

    modport slave (
        input  gwe, clear, test_stall, test_cur_pc, test_cur_insn,
        input  test_regfile_we, test_regfile_wsel, trace_pop,
        output cnt_cycles, cnt_exec, cnt_cache_stall,
        output cnt_branch_stall, cnt_load_stall,
        output halted, hung, trace_valid, trace_data, trace_overflow
    );
endinterface

// File: rtl/lc4_retire_monitor.sv
// Retire/performance monitor: cycle, exec and stall counters, halt detect,
// hang watchdog, optional retire trace FIFO (macro LC4_RETIRE_TRACE_EN).
// Ports: i_clk, i_rst (sync active-high), io_mon (lc4_retire_monitor_if.slave).
module lc4_retire_monitor #(
    parameter int            INSN          = 19,
    parameter int            IADDR         = 10,
    parameter int            REG_ADDR_BITS = 5,
    parameter int            CNT_W         = 32,
    parameter logic [19:0]   HALT_INSN     = 20'h88000,
    parameter int            WDOG_CYCLES   = 1024,
    parameter int            TRACE_DEPTH   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    lc4_retire_monitor_if.slave    io_mon
);
    localparam int TW  = INSN + IADDR + REG_ADDR_BITS + 3;
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(WDOG_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE, S_RUN, S_HALTED, S_HUNG
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cyc, r_exec, r_cache, r_branch, r_load;
    logic [WDW-1:0]   r_wdog;
    logic             r_halted, r_hung;

    // IDLE and RUN both count: the first qualified cycle is a RUN cycle.
    wire w_active = io_mon.gwe && !io_mon.clear &&
                    (r_state == S_IDLE || r_state == S_RUN);
    wire w_exec   = w_active && (io_mon.test_stall == 2'd0);
    wire w_halt   = io_mon.test_cur_insn == HALT_INSN[INSN:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst || io_mon.clear) begin
            r_state  <= S_IDLE;
            r_cyc    <= '0;
            r_exec   <= '0;
            r_cache  <= '0;
            r_branch <= '0;
            r_load   <= '0;
            r_wdog   <= '0;
            r_halted <= 1'b0;
            r_hung   <= 1'b0;
        end else if (w_active) begin
            r_state <= S_RUN;
            r_cyc   <= sat_inc(r_cyc);
            case (io_mon.test_stall)
                2'd0:    r_exec   <= sat_inc(r_exec);
                2'd1:    r_cache  <= sat_inc(r_cache);
                2'd2:    r_branch <= sat_inc(r_branch);
                default: r_load   <= sat_inc(r_load);
            endcase
            if (io_mon.test_stall == 2'd0) begin
                // A retire always clears the watchdog, even on its last cycle.
                r_wdog <= '0;
                if (w_halt) begin
                    r_state  <= S_HALTED;
                    r_halted <= 1'b1;
                end
            end else begin
                r_wdog <= r_wdog + 1'b1;
                if (r_wdog == WD_LAST) begin
                    r_state <= S_HUNG;
                    r_hung  <= 1'b1;
                end
            end
        end
    end

    assign io_mon.cnt_cycles       = r_cyc;
    assign io_mon.cnt_exec         = r_exec;
    assign io_mon.cnt_cache_stall  = r_cache;
    assign io_mon.cnt_branch_stall = r_branch;
    assign io_mon.cnt_load_stall   = r_load;
    assign io_mon.halted           = r_halted;
    assign io_mon.hung             = r_hung;

`ifdef LC4_RETIRE_TRACE_EN
    localparam int AW = $clog2(TRACE_DEPTH);

    logic [TW-1:0] r_mem [TRACE_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_count;
    logic          r_ovf;

    wire [TW-1:0] w_rec = {io_mon.test_cur_pc, io_mon.test_cur_insn,
                           io_mon.test_regfile_we, io_mon.test_regfile_wsel};
    wire w_full = r_count == (AW+1)'(TRACE_DEPTH);
    wire w_pop  = io_mon.trace_pop && (r_count != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    wire w_push = w_exec && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= w_rec;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (io_mon.clear)
                r_ovf <= 1'b0;
            else if (w_exec && w_full && !w_pop)
                r_ovf <= 1'b1;
        end
    end

    assign io_mon.trace_valid    = r_count != '0;
    assign io_mon.trace_data     = (r_count != '0) ? r_mem[r_rd] : '0;
    assign io_mon.trace_overflow = r_ovf;
`else
    logic w_unused;
    assign w_unused = ^{io_mon.trace_pop, io_mon.test_cur_pc,
                        io_mon.test_regfile_we, io_mon.test_regfile_wsel,
                        w_exec};

    assign io_mon.trace_valid    = 1'b0;
    assign io_mon.trace_data     = '0;
    assign io_mon.trace_overflow = 1'b0;
`endif
endmodule

// File: doc/lc4_retire_monitor.md
Name: lc4_retire_monitor

Overview:
- On-chip performance and retire monitor. Sits directly downstream of lc4_processor and consumes its test_* retire signals, the same signals the system bench checks.
- Counts cycles, executed instructions and the three stall classes, detects the halt instruction, and flags a hung pipeline with a watchdog.
- Optionally buffers retired-instruction records in a small trace FIFO that a host or bench drains.

Parameters:
- INSN, 19, MSB index of the instruction word (insn width INSN+1).
- IADDR, 10, MSB index of the PC (PC width IADDR+1).
- REG_ADDR_BITS, 5, width of the register select.
- CNT_W, 32, width of every performance counter.
- HALT_INSN, 20'h88000, instruction encoding that terminates a run.
- WDOG_CYCLES, 1024, number of consecutive non-retiring qualified cycles that declares a hang.
- TRACE_DEPTH, 8, number of trace FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- gwe  in  1  global write enable; one processor cycle per gwe-high clock
- clear  in  1  zeroes counters and flags and returns to IDLE
- test_stall  in  2  0=exec, 1=cache stall, 2=branch stall, 3=load stall
- test_cur_pc  in  IADDR+1  PC of the retiring instruction
- test_cur_insn  in  INSN+1  retiring instruction
- test_regfile_we  in  1  retiring instruction writes the regfile
- test_regfile_wsel  in  REG_ADDR_BITS  destination register
- cnt_cycles  out  CNT_W  qualified cycles while in RUN
- cnt_exec  out  CNT_W  retired instructions
- cnt_cache_stall  out  CNT_W  test_stall==1 cycles
- cnt_branch_stall  out  CNT_W  test_stall==2 cycles
- cnt_load_stall  out  CNT_W  test_stall==3 cycles
- halted  out  1  HALT_INSN has retired
- hung  out  1  watchdog expired
- trace_valid  out  1  FIFO non-empty
- trace_data  out  INSN+IADDR+REG_ADDR_BITS+3  {pc, insn, regfile_we, wsel} at the FIFO head
- trace_pop  in  1  consume the head entry
- trace_overflow  out  1  sticky; a record was dropped

Behaviour:
- Reset (rst=1, sampled at a clk edge):
  - state=IDLE; all counters 0.
  - halted=0, hung=0, trace_overflow=0.
  - FIFO empty; trace_valid=0, trace_data=0.
- Qualified cycle means a clk edge with gwe=1. Nothing updates on non-qualified edges except FIFO pop.
- FSM:
  - IDLE to RUN on the first qualified cycle. That cycle is counted as a RUN cycle.
  - RUN to HALTED on a qualified cycle with test_stall==0 and test_cur_insn==HALT_INSN. The halt instruction itself is counted in cnt_exec and cnt_cycles and is traced.
  - RUN to HUNG when the watchdog reaches WDOG_CYCLES.
  - HALTED and HUNG are terminal. Counters freeze and no further records are traced. Only rst or clear leaves them, and both go to IDLE.
- Counting in RUN, per qualified cycle:
  - cnt_cycles increments by 1.
  - Exactly one of the exec or stall counters increments, selected by test_stall.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Watchdog:
  - Internal counter resets to 0 on every exec cycle and increments on each stall cycle.
  - hung=1 on the qualified cycle where it reaches WDOG_CYCLES.
  - A retire on that same cycle wins: the watchdog clears and hung stays 0.
- clear has priority over gwe in the same cycle. It resets counters, flags, watchdog and state, and does not touch the FIFO.
- All outputs are registered; counters reflect a cycle's event one clk after the qualifying edge.

Optional Feature:
- Macro: LC4_RETIRE_TRACE_EN.
- With the macro defined:
  - Each exec cycle in RUN pushes one record.
  - trace_data is show-ahead (head visible while trace_valid=1). trace_pop with trace_valid=1 removes the head next edge. trace_pop while empty is ignored.
  - Push while full drops the new record and sets trace_overflow (sticky until rst or clear).
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push into an empty FIFO: trace_valid rises the next cycle.
  - Pointers wrap modulo TRACE_DEPTH; occupancy uses a log2(TRACE_DEPTH)+1 count.
- Without the macro: no FIFO storage; trace_valid, trace_data and trace_overflow are constant 0; trace_pop is ignored.

Test Plan:
- Reset, then 10 qualified cycles with test_stall=0 and insn=20'h12345 -> cnt_cycles=10, cnt_exec=10, all stall counters 0, halted=0.
- Stall sequence 0,1,2,3,3,0 -> cnt_exec=2, cache=1, branch=1, load=2, cnt_cycles=6.
- Retire 20'h88000 at pc=11'h05A, then 5 more qualified cycles -> halted=1, cnt_exec includes the halt, counters frozen; clear returns to IDLE with all counters 0.
- WDOG_CYCLES=16: 16 consecutive load stalls -> hung=1 after the 16th; repeat with a retire on the 16th cycle -> hung=0.
- gwe=0 for 20 edges with test_stall toggling -> no counter changes; clear and gwe on the same edge -> counters 0.
- LC4_RETIRE_TRACE_EN, TRACE_DEPTH=8: 9 retires with no pops -> trace_overflow=1, 8 entries; pops return the first 8 in order (pc 0..7); pop and push at full -> no overflow, order preserved.
